// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg: shared state codes, command/response bytes and status-bit positions.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;

  typedef enum logic [7:0] {
    ST_POWERUP         = 8'h00,
    ST_SEND_RESET      = 8'h01,
    ST_WAIT_ACK_RESET  = 8'h02,
    ST_WAIT_BAT        = 8'h03,
    ST_WAIT_ID         = 8'h04,
    ST_SEND_ENABLE     = 8'h05,
    ST_WAIT_ACK_ENABLE = 8'h06,
    ST_STREAM          = 8'h07,
    ST_ERROR           = 8'h08
  } init_state_t;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_INHIBIT = 2'd1,
    TX_BITS    = 2'd2
  } tx_phase_t;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] ACK        = 8'hFA;
  localparam logic [7:0] BAT_OK     = 8'hAA;
  localparam logic [7:0] MOUSE_ID   = 8'h00;

  localparam int STAT_ALWAYS1 = 3;
  localparam int STAT_X_SIGN  = 4;
  localparam int STAT_Y_SIGN  = 5;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx_deserializer.sv
// ---------------------------------------------------------------------------
// ps2_rx_deserializer: line synchronizers, falling-edge strobe and 11-bit frame receiver.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_rx_deserializer #(
  parameter int unsigned FRAME_CYC = 27000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       enable,
  output logic       fall,
  output logic       data_sync,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error
);

  logic [1:0]  clk_sync;
  logic [1:0]  dat_sync;
  logic        clk_prev;
  logic [3:0]  bit_cnt;
  logic [8:0]  shift;
  logic [31:0] idle_cnt;

  assign fall      = clk_prev & ~clk_sync[1];
  assign data_sync = dat_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '0;
      dat_sync <= '0;
      clk_prev <= 1'b0;
      bit_cnt  <= '0;
      shift    <= '0;
      idle_cnt <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_data_in};
      clk_prev <= clk_sync[1];
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (fall) idle_cnt <= '0;
      else if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;

      if (!enable) begin
        bit_cnt <= '0;
      end else if (fall) begin
        if (bit_cnt == 4'd0) begin
          if (!data_sync) bit_cnt <= 4'd1;
        end else if (bit_cnt < 4'd10) begin
          // data bits then parity land in shift[7:0] and shift[8]
          shift   <= {data_sync, shift[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          bit_cnt <= '0;
          if (data_sync && (^shift)) begin
            rx_byte  <= shift[7:0];
            rx_valid <= 1'b1;
          end else begin
            rx_error <= 1'b1;
          end
        end
      end else if (bit_cnt != 4'd0 && idle_cnt >= FRAME_CYC - 1) begin
        bit_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_mouse_host.sv
// ---------------------------------------------------------------------------
// ps2_mouse_host: mouse init sequencer, host transmitter and stream packet assembly.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_mouse_host
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ       = 27000000,
  parameter int unsigned INHIBIT_US        = 100,
  parameter int unsigned POWERUP_MS        = 10,
  parameter int unsigned RESP_TIMEOUT_MS   = 500,
  parameter int unsigned FRAME_TIMEOUT_US  = 1000,
  parameter int unsigned PACKET_TIMEOUT_US = 150
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        ps2_clk,
  inout  wire        ps2_data,
  output logic [7:0] debug_state,
  output logic [7:0] debug_data,
  output logic       debug_busy,
  output logic       debug_ack,
  output logic       init_done,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic [8:0] mouse_x,
  output logic [8:0] mouse_y,
  output logic [2:0] buttons,
  output logic       packet_ready,
  output logic       rx_error
);

  localparam int unsigned POWERUP_CYC = CLK_FREQ_HZ / 1000 * POWERUP_MS;
  localparam int unsigned RESP_CYC    = CLK_FREQ_HZ / 1000 * RESP_TIMEOUT_MS;
  localparam int unsigned INHIBIT_CYC = CLK_FREQ_HZ / 1000000 * INHIBIT_US;
  localparam int unsigned FRAME_CYC   = CLK_FREQ_HZ / 1000000 * FRAME_TIMEOUT_US;
  localparam int unsigned PKT_CYC     = CLK_FREQ_HZ / 1000000 * PACKET_TIMEOUT_US;

  init_state_t state, tx_next, rx_next;
  tx_phase_t   tx_phase;
  logic [31:0] timer, gap_cnt;
  logic [8:0]  tx_shift;
  logic [3:0]  tx_cnt;
  logic [7:0]  cmd, exp_byte, rx_byte, x_byte;
  logic [5:0]  status;
  logic [1:0]  idx;
  logic        clk_oe, data_oe, busy, ack_seen, gap_flag;
  logic        fall, data_sync, rx_valid, rx_err;

  assign ps2_clk  = clk_oe  ? 1'b0 : 1'bz;
  assign ps2_data = data_oe ? 1'b0 : 1'bz;

  ps2_rx_deserializer #(.FRAME_CYC(FRAME_CYC)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk_in  (ps2_clk),
    .ps2_data_in (ps2_data),
    .enable      (~busy),
    .fall        (fall),
    .data_sync   (data_sync),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_error    (rx_err)
  );

  assign debug_state   = state;
  assign debug_data    = rx_byte;
  assign rx_data       = rx_byte;
  assign rx_data_valid = rx_valid;
  assign rx_error      = rx_err;
  assign debug_busy    = busy;
  assign debug_ack     = ack_seen;
  assign init_done     = (state == ST_STREAM);

  always_comb begin
    cmd      = CMD_RESET;
    tx_next  = ST_WAIT_ACK_RESET;
    exp_byte = ACK;
    rx_next  = ST_WAIT_BAT;
    case (state)
      ST_SEND_ENABLE:     begin cmd = CMD_ENABLE; tx_next = ST_WAIT_ACK_ENABLE; end
      ST_WAIT_BAT:        begin exp_byte = BAT_OK;   rx_next = ST_WAIT_ID;     end
      ST_WAIT_ID:         begin exp_byte = MOUSE_ID; rx_next = ST_SEND_ENABLE; end
      ST_WAIT_ACK_ENABLE: rx_next = ST_STREAM;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_POWERUP;
      tx_phase <= TX_IDLE;
      timer    <= '0;
      tx_shift <= '0;
      tx_cnt   <= '0;
      clk_oe   <= 1'b0;
      data_oe  <= 1'b0;
      busy     <= 1'b0;
      ack_seen <= 1'b0;
    end else begin
      if (timer != '1) timer <= timer + 1'b1;
      case (state)
        ST_POWERUP, ST_ERROR:
          if (timer >= POWERUP_CYC - 1) begin
            state <= ST_SEND_RESET;
            timer <= '0;
          end
        ST_SEND_RESET, ST_SEND_ENABLE:
          case (tx_phase)
            TX_IDLE: begin
              tx_phase <= TX_INHIBIT;
              clk_oe   <= 1'b1;
              busy     <= 1'b1;
              ack_seen <= 1'b0;
              timer    <= '0;
              tx_cnt   <= '0;
              tx_shift <= {odd_parity(cmd), cmd};
            end
            TX_INHIBIT:
              if (timer >= INHIBIT_CYC - 1) begin
                clk_oe   <= 1'b0;
                data_oe  <= 1'b1;
                tx_phase <= TX_BITS;
                timer    <= '0;
              end
            default:
              if (timer >= RESP_CYC - 1) begin
                state    <= ST_ERROR;
                tx_phase <= TX_IDLE;
                data_oe  <= 1'b0;
                busy     <= 1'b0;
                timer    <= '0;
              end else if (fall) begin
                timer  <= '0;
                tx_cnt <= tx_cnt + 4'd1;
                if (tx_cnt < 4'd9) begin
                  data_oe  <= ~tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[8:1]};
                end else if (tx_cnt == 4'd9) begin
                  data_oe <= 1'b0;
                end else begin
                  // eleventh falling edge: device must be pulling data low
                  busy     <= 1'b0;
                  tx_phase <= TX_IDLE;
                  state    <= data_sync ? ST_ERROR : tx_next;
                end
              end
          endcase
        ST_WAIT_ACK_RESET, ST_WAIT_BAT, ST_WAIT_ID, ST_WAIT_ACK_ENABLE:
          if (rx_err || timer >= RESP_CYC - 1) begin
            state <= ST_ERROR;
            timer <= '0;
          end else if (rx_valid) begin
            timer <= '0;
            if (rx_byte == exp_byte) begin
              state <= rx_next;
              if (exp_byte == ACK) ack_seen <= 1'b1;
            end else begin
              state <= ST_ERROR;
            end
          end
        default: ;
      endcase
    end
  end

  // Gap detection watches ps2_clk idle time, so back-to-back bytes never trip it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt      <= '0;
      gap_flag     <= 1'b0;
      idx          <= '0;
      status       <= '0;
      x_byte       <= '0;
      mouse_x      <= '0;
      mouse_y      <= '0;
      buttons      <= '0;
      packet_ready <= 1'b0;
    end else begin
      packet_ready <= 1'b0;
      if (fall) gap_cnt <= '0;
      else if (gap_cnt != '1) gap_cnt <= gap_cnt + 1'b1;
      if (gap_cnt >= PKT_CYC - 1) gap_flag <= 1'b1;

      if (state != ST_STREAM || rx_err) begin
        idx <= '0;
      end else if (rx_valid) begin
        gap_flag <= 1'b0;
        case (gap_flag ? 2'd0 : idx)
          2'd0:
            if (rx_byte[STAT_ALWAYS1]) begin
              status <= rx_byte[5:0];
              idx    <= 2'd1;
            end else begin
              idx <= 2'd0;
            end
          2'd1: begin
            x_byte <= rx_byte;
            idx    <= 2'd2;
          end
          default: begin
            mouse_x      <= {status[STAT_X_SIGN], x_byte};
            mouse_y      <= {status[STAT_Y_SIGN], rx_byte};
            buttons      <= status[2:0];
            packet_ready <= 1'b1;
            idx          <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_mouse_host.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_host: PS/2 mouse device model with scoreboarded receive and packet checks.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_mouse_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  wire        ps2_clk;
  wire        ps2_data;
  logic [7:0] debug_state, debug_data, rx_data;
  logic       debug_busy, debug_ack, init_done, rx_data_valid, packet_ready, rx_error;
  logic [8:0] mouse_x, mouse_y;
  logic [2:0] buttons;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  always #250 clk = ~clk;

  ps2_mouse_host #(
    .CLK_FREQ_HZ       (2000000),
    .INHIBIT_US        (100),
    .POWERUP_MS        (1),
    .RESP_TIMEOUT_MS   (2),
    .FRAME_TIMEOUT_US  (1000),
    .PACKET_TIMEOUT_US (150)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .debug_state   (debug_state),
    .debug_data    (debug_data),
    .debug_busy    (debug_busy),
    .debug_ack     (debug_ack),
    .init_done     (init_done),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .mouse_x       (mouse_x),
    .mouse_y       (mouse_y),
    .buttons       (buttons),
    .packet_ready  (packet_ready),
    .rx_error      (rx_error)
  );

  typedef struct {
    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] b;
  } pkt_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_err  = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  pkt_t       exp_pkt[$];
  logic [7:0] seen[$];
  logic [7:0] last_state = 8'h00;
  bit         rec_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rx_data_valid) begin
      check("rx_expected", 32'(exp_rx.size() > 0), 1);
      if (exp_rx.size() > 0) begin
        check("rx_data", rx_data, exp_rx[0]);
        check("debug_data", debug_data, exp_rx[0]);
        void'(exp_rx.pop_front());
      end
    end
    if (rx_error) begin
      check("rx_error_expected", 32'(exp_err > 0), 1);
      if (exp_err > 0) exp_err--;
    end
    if (packet_ready) begin
      check("pkt_expected", 32'(exp_pkt.size() > 0), 1);
      if (exp_pkt.size() > 0) begin
        check("pkt_mouse_x", mouse_x, exp_pkt[0].x);
        check("pkt_mouse_y", mouse_y, exp_pkt[0].y);
        check("pkt_buttons", buttons, exp_pkt[0].b);
        void'(exp_pkt.pop_front());
      end
    end
    if (rec_en && debug_state != last_state) begin
      seen.push_back(debug_state);
      last_state = debug_state;
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit bad);
    logic [10:0] bits;
    logic        par;
    par = ~^b;
    if (bad) par = ~par;
    bits = {1'b1, par, b, 1'b0};
    if (bad) exp_err++;
    else exp_rx.push_back(b);
    for (int i = 0; i < 11; i++) begin
      dev_data_low = ~bits[i];
      #5us  dev_clk_low = 1'b1;
      #15us dev_clk_low = 1'b0;
      #10us;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y,
                             input logic [8:0] ex, input logic [8:0] ey, input logic [2:0] eb);
    pkt_t p;
    p.x = ex; p.y = ey; p.b = eb;
    exp_pkt.push_back(p);
    send_frame(s, 1'b0); #20us;
    send_frame(x, 1'b0); #20us;
    send_frame(y, 1'b0);
  endtask

  // Device side of a host-to-device transfer: clock in 8 data, parity, stop, then ack.
  task automatic dev_receive();
    logic [7:0] b;
    logic       p, stop;
    int         n;
    b = '0; p = 1'b0; stop = 1'b0;
    n = 0;
    while (ps2_clk !== 1'b0 && n < 20000) begin @(posedge clk); n++; end
    check("host_inhibit", 32'(ps2_clk), 0);
    n = 0;
    while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && n < 2000) begin @(posedge clk); n++; end
    check("host_rts", {ps2_clk, ps2_data}, 2'b10);
    check("busy_during_tx", 32'(debug_busy), 1);
    #20us;
    for (int k = 0; k < 11; k++) begin
      dev_clk_low = 1'b1;
      #15us dev_clk_low = 1'b0;
      #7500;
      if (k < 8) b[k] = ps2_data;
      else if (k == 8) p = ps2_data;
      else if (k == 9) begin stop = ps2_data; dev_data_low = 1'b1; end
      else dev_data_low = 1'b0;
      #7500;
    end
    check("tx_expected", 32'(exp_tx.size() > 0), 1);
    if (exp_tx.size() > 0) begin
      check("tx_byte", b, exp_tx[0]);
      void'(exp_tx.pop_front());
    end
    check("tx_parity_odd", 32'(^{p, b}), 1);
    check("tx_stop_released", 32'(stop), 1);
    check("busy_after_ack", 32'(debug_busy), 0);
  endtask

  initial begin
    seen.push_back(8'h00);
    repeat (5) @(posedge clk);
    #1;
    check("rst_state", debug_state, 8'h00);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_outputs", {rx_data, mouse_x, mouse_y, buttons, debug_busy, debug_ack}, 0);
    check("rst_lines", {ps2_clk, ps2_data}, 2'b11);
    @(negedge clk) rst_n = 1'b1;

    exp_tx.push_back(8'hFF);
    dev_receive();
    #100us send_frame(8'hFA, 1'b0);
    #50us  send_frame(8'hAA, 1'b0);
    #50us  send_frame(8'h00, 1'b0);
    exp_tx.push_back(8'hF4);
    dev_receive();
    #100us send_frame(8'hFA, 1'b0);
    for (int i = 0; i < 4000 && !init_done; i++) @(posedge clk);
    #1;
    check("init_done", 32'(init_done), 1);
    check("init_state", debug_state, 8'h07);
    check("init_ack", 32'(debug_ack), 1);
    rec_en = 1'b0;
    check("state_walk_len", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) check("state_walk", seen[i], i);

    #300us;
    send_frame(8'hAA, 1'b0); #20us;
    send_frame(8'h55, 1'b0);

    #300us send_packet(8'h08, 8'h05, 8'h05, 9'h005, 9'h005, 3'b000);
    #300us send_packet(8'h09, 8'h0A, 8'h0A, 9'h00A, 9'h00A, 3'b001);
    #300us send_packet(8'h3F, 8'hF9, 8'hF9, 9'h1F9, 9'h1F9, 3'b111);
    #300us send_packet(8'h3B, 8'hF4, 8'hF4, 9'h1F4, 9'h1F4, 3'b011);

    #300us send_frame(8'h09, 1'b0);
    #20us  send_frame(8'hAA, 1'b1);
    #5us;
    check("hold_after_err", {mouse_x, mouse_y, buttons}, {9'h1F4, 9'h1F4, 3'b011});
    #15us  send_packet(8'h08, 8'h03, 8'h02, 9'h003, 9'h002, 3'b000);

    #300us send_frame(8'h00, 1'b0);
    #20us  send_packet(8'h08, 8'h01, 8'h02, 9'h001, 9'h002, 3'b000);

    #100us;
    check("rx_queue_drained", exp_rx.size(), 0);
    check("pkt_queue_drained", exp_pkt.size(), 0);
    check("err_count_drained", exp_err, 0);

    @(negedge clk) rst_n = 1'b0;
    #2us;
    check("rst2_state", {debug_state, 7'(init_done)}, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10000 && debug_state != 8'h08; i++) @(posedge clk);
    #1;
    check("silent_error", debug_state, 8'h08);
    check("silent_released", {ps2_clk, ps2_data, debug_busy}, 3'b110);
    for (int i = 0; i < 4000 && debug_state != 8'h01; i++) @(posedge clk);
    #1;
    check("silent_retry", debug_state, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100ms;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/ps2_mouse_host.md
Name: ps2_mouse_host

Overview:
PS/2 host controller for a standard 3-button mouse. After reset it initializes the device (reset, self-test, enable reporting), then stays in stream mode. In stream mode it deserializes 11-bit frames, assembles 3-byte movement packets, and presents signed deltas and button states to downstream logic. The PS/2 lines are open-drain board pins.

Parameters:
CLK_FREQ_HZ, 27000000, system clock frequency; all timers derive from it.
INHIBIT_US, 100, host clock-inhibit time before a request-to-send.
POWERUP_MS, 10, wait after reset before the first command.
RESP_TIMEOUT_MS, 500, maximum wait for any device response or device clock during init.
FRAME_TIMEOUT_US, 1000, idle time on ps2_clk with no falling edge that aborts a partial frame.
PACKET_TIMEOUT_US, 150, gap between stream bytes that resets packet byte alignment to byte 0.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset.
ps2_clk  inout  1  PS/2 clock; open-drain, driven 0 or Z.
ps2_data  inout  1  PS/2 data; open-drain, driven 0 or Z.
debug_state  out  8  current init FSM state code.
debug_data  out  8  last byte received.
debug_busy  out  1  host transmitter active.
debug_ack  out  1  last command acknowledged with 0xFA (sticky until the next command).
init_done  out  1  high while in STREAM_MODE.
rx_data  out  8  last received byte.
rx_data_valid  out  1  1-cycle pulse on a good frame.
mouse_x  out  9  two's-complement X delta.
mouse_y  out  9  two's-complement Y delta.
buttons  out  3  {middle, right, left}.
packet_ready  out  1  1-cycle pulse when a packet is complete.
rx_error  out  1  1-cycle pulse on a bad frame.

Behaviour:
- Reset and sync: one clock domain; reset is asynchronous and active-low (rst_n). On reset all outputs are 0, both lines are released (Z), and state is 0x00. Both lines pass through 2-FF synchronizers. A falling edge of the synchronized clock is the sample strobe.
- Receiver framing: start=0, 8 data bits LSB first, odd parity, stop=1. Data is sampled on the falling edge.
  - After the stop bit: if parity and stop are correct, rx_data_valid pulses 1 cycle and rx_data/debug_data update. Otherwise rx_error pulses 1 cycle and data is not updated.
  - A start bit sampled as 1 is ignored.
  - No falling edge for FRAME_TIMEOUT_US aborts a partial frame silently.
  - Worst-case latency from the stop-bit falling edge to the pulse is 4 clk.
  - The receiver is disabled while the host transmits.
- Transmitter (host to device):
  - Hold ps2_clk low for INHIBIT_US, then drive data low and release the clock.
  - On each device falling edge, present the next bit: 8 data bits LSB first, odd parity, then release data for the stop bit.
  - Wait for the device ack: data low on the next falling edge.
  - debug_busy is high from inhibit until the ack. A response timeout enters ERROR.
- Init FSM state codes:
  - 0x00 POWERUP: wait POWERUP_MS.
  - 0x01 SEND_RESET: send 0xFF.
  - 0x02 WAIT_ACK_RESET: expect 0xFA.
  - 0x03 WAIT_BAT: expect 0xAA.
  - 0x04 WAIT_ID: expect 0x00.
  - 0x05 SEND_ENABLE: send 0xF4.
  - 0x06 WAIT_ACK_ENABLE: expect 0xFA.
  - 0x07 STREAM_MODE: terminal state.
  - 0x08 ERROR: wait POWERUP_MS, then return to 0x01.
  - Any wrong byte, rx_error, or timeout in states 0x01–0x06 goes to 0x08.
  - init_done = (state == 0x07).
- Packet assembly (STREAM_MODE only), on each good byte:
  - Byte 0 (status) is accepted only if bit 3 = 1; otherwise the byte is discarded and the index stays at 0.
  - Byte 1 is X, byte 2 is Y.
  - A gap longer than PACKET_TIMEOUT_US since the previous byte resets the index to 0 before the new byte is processed.
  - rx_error resets the index to 0.
  - After byte 2, in the same cycle: mouse_x = {status[4], X}, mouse_y = {status[5], Y}, buttons = status[2:0], and packet_ready pulses 1 cycle. Outputs hold until the next packet. Overflow bits are ignored.
- Reset mid-frame or mid-command aborts immediately, releases the lines, and restarts at POWERUP.

Decomposition:
- Package ps2_pkg holds:
  - state codes 0x00–0x08;
  - command bytes CMD_RESET=0xFF and CMD_ENABLE=0xF4;
  - responses ACK=0xFA, BAT_OK=0xAA, MOUSE_ID=0x00;
  - the status-byte bit positions.
- Sub-module ps2_rx_deserializer contains the synchronizers, edge detector, framing, parity check and frame timeout. Transmitter, FSM and packet assembly stay in the top level.

Test Plan:
1. Init handshake: device model returns 0xFA, 0xAA, 0x00 after 0xFF, then 0xFA after 0xF4 -> host-sent bytes are 0xFF and 0xF4 with correct parity; debug_state walks 0x00..0x07; init_done=1.
2. Raw receive: frames 0xAA then 0x55 at a 30 µs PS/2 clock period -> rx_data_valid pulses with 0xAA, then 0x55; no rx_error.
3. Packets, each sent 300+ µs after the previous one (the 0xAA/0x55 pair is flushed by the gap):
   - status 0x08, X 0x05, Y 0x05 -> mouse_x=5, mouse_y=5, buttons=000, one packet_ready.
   - status 0x09, X 0x0A, Y 0x0A -> 10, 10, buttons=001.
4. Negative deltas and buttons:
   - status 0x3F, X 0xF9, Y 0xF9 -> mouse_x=mouse_y=-7 (0x1F9), buttons=111.
   - status 0x3B, X 0xF4, Y 0xF4 -> -12, -12, buttons=011.
5. Parity error: frame 0xAA with parity bit 0 -> rx_error pulse; no rx_data_valid; packet index reset; mouse outputs unchanged.
6. Resync and timeouts:
   - stream byte 0x00 (bit3=0) as first byte -> discarded, no packet.
   - init: device silent -> ERROR (0x08) then retry at 0x01.
